// File: rtl/ram_pkg.sv
// ============================================================================
// Module      : ram_pkg
// Description : Shared sizing constants and access-op decode for the ram block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_pkg;

  localparam int c_DATA_WIDTH = 32;
  localparam int c_ADDR_WIDTH = 10;
  localparam int c_DEPTH      = 1 << c_ADDR_WIDTH;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_e;

  // en qualifies wr_rdn; with en low the direction bit is ignored.
  function automatic op_e decode_op(input logic en, input logic wr_rdn);
    op_e op;
    op = OP_IDLE;
    if (en) begin
      op = wr_rdn ? OP_WRITE : OP_READ;
    end
    return op;
  endfunction

endpackage : ram_pkg

`default_nettype wire

// File: rtl/ram_array.sv
// ============================================================================
// Module      : ram_array
// Description : Plain single-port storage; synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_array #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int c_DEPTH = 1 << ADDR_WIDTH;

  // No reset on the array so it maps onto block RAM.
  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule : ram_array

`default_nettype wire

// File: rtl/ram.sv
// ============================================================================
// Module      : ram
// Description : Single-port synchronous RAM with registered, resettable read data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int ADDR_WIDTH = c_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  wr_rdn,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_wr,
  output logic [DATA_WIDTH-1:0] data_rd
);

  op_e                   w_op;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_mem_rd;
  logic [DATA_WIDTH-1:0] r_data_rd;

  assign w_op = decode_op(en, wr_rdn);

  // The array has no reset, so writes are blocked explicitly while rstn is low.
  assign w_we = (w_op == OP_WRITE) && rstn;

  ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (addr),
    .i_wdata (data_wr),
    .o_rdata (w_mem_rd)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data_rd <= '0;
    end else if (w_op == OP_READ) begin
      r_data_rd <= w_mem_rd;
    end
  end

  assign data_rd = r_data_rd;

endmodule : ram

`default_nettype wire

// File: tb/tb_ram.sv
// ============================================================================
// Module      : tb_ram
// Description : Randomized scoreboard bench for ram against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        wr_rdn = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] data_wr = '0;
  logic [31:0] data_rd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] model_mem [int];
  logic [31:0] exp_out = '0;
  logic [31:0] exp_q [$];
  logic [9:0]  pool [16];

  ram u_dut (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .wr_rdn  (wr_rdn),
    .addr    (addr),
    .data_wr (data_wr),
    .data_rd (data_rd)
  );

  always #5 clk = ~clk;

  // One clock cycle of stimulus; the expected data_rd after the coming edge is queued.
  task automatic cycle(input logic r, input logic e, input logic w,
                       input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    rstn = r; en = e; wr_rdn = w; addr = a; data_wr = d;
    if (!r) begin
      exp_out = '0;
    end else if (e && w) begin
      model_mem[int'(a)] = d;
    end else if (e) begin
      exp_out = model_mem.exists(int'(a)) ? model_mem[int'(a)] : 'x;
    end
    exp_q.push_back(exp_out);
  endtask

  // Reset dropped mid-cycle while an operation is presented.
  task automatic reset_mid(input logic e, input logic w,
                           input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    en = e; wr_rdn = w; addr = a; data_wr = d;
    #2 rstn = 1'b0;
    exp_out = '0;
    exp_q.push_back(exp_out);
  endtask

  // Monitor: clock edges pop the scoreboard; a falling rstn must clear data_rd at once.
  initial begin
    logic [31:0] exp;
    forever begin
      @(posedge clk or negedge rstn);
      if (clk) begin
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          if (!$isunknown(exp)) begin
            checks++;
            if (data_rd !== exp) begin
              errors++;
              $display("FAIL data_rd cycle %0d: got %h expected %h", cyc, data_rd, exp);
            end
          end
        end
      end else begin
        #1;
        checks++;
        if (data_rd !== 32'h0) begin
          errors++;
          $display("FAIL async_reset_clear: got %h expected %h", data_rd, 32'h0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    logic e, w;

    // Reset and idle after release.
    cycle(0, 0, 0, 10'h000, 32'h0);
    cycle(1, 0, 0, 10'h000, 32'h0);
    cycle(1, 0, 0, 10'h000, 32'h0);

    // Single write/read, then hold while idle.
    cycle(1, 1, 1, 10'h155, 32'hDEADBEEF);
    cycle(1, 1, 0, 10'h155, 32'h0);
    cycle(1, 0, 0, 10'h155, 32'h0);
    cycle(1, 0, 1, 10'h155, 32'h12345678);

    // Several writes including both address extremes, read back in order.
    cycle(1, 1, 1, 10'h001, 32'h11111111);
    cycle(1, 1, 1, 10'h3FF, 32'h22222222);
    cycle(1, 1, 1, 10'h200, 32'h33333333);
    cycle(1, 1, 1, 10'h000, 32'h5A5A0000);
    cycle(1, 1, 0, 10'h001, 32'h0);
    cycle(1, 1, 0, 10'h3FF, 32'h0);
    cycle(1, 1, 0, 10'h200, 32'h0);
    cycle(1, 1, 0, 10'h000, 32'h0);

    // A write leaves data_rd untouched.
    cycle(1, 1, 0, 10'h001, 32'h0);
    cycle(1, 1, 1, 10'h002, 32'hAAAAAAAA);
    cycle(1, 0, 0, 10'h002, 32'h0);

    // Reset mid-operation; contents survive, writes during reset are dropped.
    reset_mid(1, 0, 10'h3FF, 32'h0);
    cycle(0, 1, 1, 10'h001, 32'h55555555);
    cycle(1, 0, 0, 10'h000, 32'h0);
    cycle(1, 1, 0, 10'h3FF, 32'h0);
    cycle(1, 1, 0, 10'h001, 32'h0);

    // Back-to-back mix.
    cycle(1, 1, 1, 10'h010, 32'h0BADF00D);
    cycle(1, 1, 0, 10'h010, 32'h0);
    cycle(1, 1, 0, 10'h200, 32'h0);

    // Randomized traffic over a small address pool so reads hit written words.
    pool[0] = 10'h000;
    pool[1] = 10'h3FF;
    for (int i = 2; i < 16; i++) pool[i] = 10'($urandom_range(0, 1023));
    for (int i = 0; i < 16; i++) cycle(1, 1, 1, pool[i], $urandom);
    for (int i = 0; i < 400; i++) begin
      idx = int'($urandom_range(0, 15));
      e = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 39) == 0) begin
        cycle(0, e, w, pool[idx], $urandom);
      end else begin
        cycle(1, e, w, pool[idx], $urandom);
      end
    end
    cycle(1, 0, 0, 10'h000, 32'h0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ram

`default_nettype wire
